// File: rtl/regfile_pkg.sv
// regfile_pkg: shared register-file widths, constants and control levels.
package regfile_pkg;
  localparam int RegNum = 32;
  localparam int RegNumLog2 = 5;
  localparam int RegDataWidth = 32;
  typedef logic [RegNumLog2-1:0] reg_addr_t;
  typedef logic [RegDataWidth-1:0] reg_data_t;
  localparam reg_data_t ZeroWord = 32'h0000_0000;
  localparam reg_addr_t NOPRegAddr = 5'd0;
  localparam logic RstEnable = 1'b1;
  localparam logic WriteEnable = 1'b1;
  localparam logic ReadEnable = 1'b1;
endpackage

// File: rtl/regfile_rdport.sv
// regfile_rdport: one combinational read port with same-cycle write-through bypass.
module regfile_rdport
  import regfile_pkg::*;
(
  input  logic      rst,
  input  logic      re,
  input  reg_addr_t raddr,
  input  reg_data_t word,
  input  logic      we,
  input  reg_addr_t waddr,
  input  reg_data_t wdata,
  output reg_data_t rdata
);
  logic rd_en;
  logic bypass;
  always_comb begin
    rd_en  = (rst != RstEnable) && (raddr != NOPRegAddr) && (re == ReadEnable);
    bypass = (we == WriteEnable) && (raddr == waddr);
    rdata  = !rd_en ? ZeroWord : bypass ? wdata : word;
  end
endmodule

// File: rtl/regfile.sv
// regfile: 32x32 register file, one write port, two bypassing read ports; r0 reads as zero.
module regfile
  import regfile_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      we,
  input  reg_addr_t waddr,
  input  reg_data_t wdata,
  input  logic      re1,
  input  reg_addr_t raddr1,
  output reg_data_t rdata1,
  input  logic      re2,
  input  reg_addr_t raddr2,
  output reg_data_t rdata2
);
  reg_data_t regs [RegNum];
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      for (int i = 0; i < RegNum; i++) regs[i] <= ZeroWord;
    end else if (we == WriteEnable && waddr != NOPRegAddr) begin
      regs[waddr] <= wdata;
    end
  end
  regfile_rdport u_rd1 (
    .rst(rst), .re(re1), .raddr(raddr1), .word(regs[raddr1]),
    .we(we), .waddr(waddr), .wdata(wdata), .rdata(rdata1)
  );
  regfile_rdport u_rd2 (
    .rst(rst), .re(re2), .raddr(raddr2), .word(regs[raddr2]),
    .we(we), .waddr(waddr), .wdata(wdata), .rdata(rdata2)
  );
endmodule

// File: tb/tb_regfile.sv
// tb_regfile: directed vector table plus reset-flood sequence for regfile.
module tb_regfile;
  logic clk = 1'b0;
  logic rst, we, re1, re2;
  logic [4:0] waddr, raddr1, raddr2;
  logic [31:0] wdata, rdata1, rdata2;
  int total = 0;
  int bad = 0;
  typedef struct packed {
    logic rst; logic we; logic [4:0] waddr; logic [31:0] wdata;
    logic re1; logic [4:0] ra1; logic re2; logic [4:0] ra2;
    logic [31:0] e1; logic [31:0] e2;
  } vec_t;
  vec_t v [17];
  regfile dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
    .re2(re2), .raddr2(raddr2), .rdata2(rdata2)
  );
  always #5 clk = ~clk;
  function automatic vec_t mk(logic r, logic w, logic [4:0] wa, logic [31:0] wd,
                              logic r1, logic [4:0] a1, logic r2, logic [4:0] a2,
                              logic [31:0] x1, logic [31:0] x2);
    mk = '{r, w, wa, wd, r1, a1, r2, a2, x1, x2};
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask
  task automatic drive(input vec_t t);
    @(negedge clk);
    rst = t.rst; we = t.we; waddr = t.waddr; wdata = t.wdata;
    re1 = t.re1; raddr1 = t.ra1; re2 = t.re2; raddr2 = t.ra2;
    #2;
  endtask
  initial begin
    rst = 1; we = 0; waddr = 0; wdata = 0; re1 = 0; raddr1 = 0; re2 = 0; raddr2 = 0;
    v[0]  = mk(1, 0, 0, 0,            1, 5,  1, 5,  0,            0);
    v[1]  = mk(0, 1, 5, 32'h12345678, 1, 5,  1, 6,  32'h12345678, 0);
    v[2]  = mk(0, 0, 0, 0,            1, 5,  0, 5,  32'h12345678, 0);
    v[3]  = mk(0, 0, 0, 0,            0, 5,  1, 5,  0,            32'h12345678);
    v[4]  = mk(0, 1, 0, 32'hDEADBEEF, 1, 0,  1, 0,  0,            0);
    v[5]  = mk(0, 0, 0, 0,            1, 0,  1, 5,  0,            32'h12345678);
    v[6]  = mk(0, 1, 7, 32'h1,        0, 7,  0, 7,  0,            0);
    v[7]  = mk(0, 1, 7, 32'hA5A5A5A5, 1, 7,  1, 7,  32'hA5A5A5A5, 32'hA5A5A5A5);
    v[8]  = mk(0, 0, 7, 32'hFFFF0000, 1, 7,  1, 5,  32'hA5A5A5A5, 32'h12345678);
    v[9]  = mk(0, 1, 9, 32'h11111111, 1, 9,  1, 7,  32'h11111111, 32'hA5A5A5A5);
    v[10] = mk(0, 1, 9, 32'h22222222, 1, 9,  1, 9,  32'h22222222, 32'h22222222);
    v[11] = mk(0, 0, 0, 0,            1, 9,  1, 31, 32'h22222222, 0);
    v[12] = mk(1, 1, 3, 32'h55,       1, 3,  1, 9,  0,            0);
    v[13] = mk(0, 0, 0, 0,            1, 3,  1, 9,  0,            0);
    v[14] = mk(0, 0, 0, 0,            1, 5,  1, 7,  0,            0);
    v[15] = mk(0, 1, 31, 32'hCAFEF00D, 1, 31, 1, 30, 32'hCAFEF00D, 0);
    v[16] = mk(0, 0, 0, 0,            1, 31, 1, 31, 32'hCAFEF00D, 32'hCAFEF00D);
    for (int i = 0; i < 17; i++) begin
      drive(v[i]);
      chk($sformatf("vec%0d_rd1", i), rdata1, v[i].e1);
      chk($sformatf("vec%0d_rd2", i), rdata2, v[i].e2);
    end
    for (int i = 1; i < 32; i++) drive(mk(0, 1, 5'(i), 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0));
    drive(mk(0, 0, 0, 0, 1, 1, 1, 31, 0, 0));
    chk("flood_rd1", rdata1, 32'hFFFFFFFF);
    chk("flood_rd2", rdata2, 32'hFFFFFFFF);
    drive(mk(1, 0, 0, 0, 1, 12, 1, 20, 0, 0));
    chk("in_rst_rd1", rdata1, 32'h0);
    chk("in_rst_rd2", rdata2, 32'h0);
    for (int i = 0; i < 32; i++) begin
      drive(mk(0, 0, 0, 0, 1, 5'(i), 1, 5'(31 - i), 0, 0));
      chk($sformatf("post_rst_rd1_r%0d", i), rdata1, 32'h0);
      chk($sformatf("post_rst_rd2_r%0d", 31 - i), rdata2, 32'h0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
